// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//
// Multi-cycle MIPS-style control unit. A Moore FSM walks each instruction
// through FETCH/DECODE and then the memory, ALU, branch or jump path, and
// drives the datapath enables and mux selects for the current state. Only the
// mem_ready qualification (FETCH) and the zero qualification (BRANCH) depend
// combinationally on inputs.
//
// Extra behaviour on top of the basic control flow:
//   - a wait counter traps the FSM when memory stalls for too long,
//   - illegal opcodes/functs trap and set a sticky illegal_instr flag,
//   - a retired-instruction counter (instr_count).
//
// Build option:
//   MC_CTRL_BNE_EN - when defined, opcode 000101 (BNE) is decoded as a branch
//                    taken on !zero; when undefined it is an illegal opcode.
//
// Parameters:
//   WAIT_MAX - consecutive mem_ready=0 cycles tolerated in a memory state
//              before trapping (0 disables the timeout)
//   CNT_W    - width of instr_count
//
// Ports:
//   CLK, FSMRST          - clock (rising edge), async active-high reset
//   opcode, funct        - instruction fields from the instruction register
//   zero                 - ALU result equals zero
//   mem_ready            - memory access completes this cycle
//   RFWE, MWE, IRWE, PCE - register file / memory / IR / PC write enables
//   ALU_sel, ALU_in_sel1, ALU_in_sel2, M_to_RF_sel, RFD_sel, ID_sel, PC_sel
//                        - datapath mux and ALU operation selects
//   illegal_instr        - sticky, set on a trap taken from DECODE
//   timeout              - sticky, set on a memory wait timeout
//   instr_count          - retired instruction count (wraps)
//   state                - current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             FSMRST,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             RFWE,
    output logic             MWE,
    output logic             IRWE,
    output logic             PCE,
    output logic [3:0]       ALU_sel,
    output logic             M_to_RF_sel,
    output logic [1:0]       ALU_in_sel1,
    output logic [1:0]       ALU_in_sel2,
    output logic             RFD_sel,
    output logic             ID_sel,
    output logic [1:0]       PC_sel,
    output logic             illegal_instr,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    localparam int WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] F_SLL    = 6'b000000;
    localparam logic [5:0] F_SLLV   = 6'b000100;
    localparam logic [5:0] F_SRAV   = 6'b000111;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_XOR    = 6'b100110;

    localparam logic [3:0] ALU_SUB  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_WB    = 4'd10,
        S_TRAP      = 4'd11
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WCNT_W-1:0]  r_waitCnt;
    logic [CNT_W-1:0]   r_instrCount;
    logic               r_illegal;
    logic               r_timeout;

    logic               w_functLegal;
    logic [3:0]         w_execAluSel;
    logic [1:0]         w_execIn1;
    logic               w_waitState;
    logic               w_timeoutHit;
    logic               w_retire;
    logic               w_rfwe;
    logic               w_mwe;

`ifdef MC_CTRL_BNE_EN
    logic               r_isBne;
`endif

    // R-type function decode: legality for DECODE and the ALU operation used
    // in EXECUTE. Shift-by-shamt (funct 000000) takes its first ALU operand
    // from the shamt path instead of rs.
    always_comb begin
        w_functLegal = 1'b1;
        w_execAluSel = ALU_SUB;
        w_execIn1    = 2'b01;
        case (funct)
            F_ADD:  w_execAluSel = ALU_ADD;
            F_SUB:  w_execAluSel = ALU_SUB;
            F_AND:  w_execAluSel = ALU_AND;
            F_OR:   w_execAluSel = ALU_OR;
            F_XOR:  w_execAluSel = ALU_XOR;
            F_SLLV: w_execAluSel = ALU_SLL;
            F_SRAV: w_execAluSel = ALU_SRA;
            F_SLL: begin
                w_execAluSel = ALU_SLL;
                w_execIn1    = 2'b10;
            end
            default: w_functLegal = 1'b0;
        endcase
    end

    // The timeout fires on the cycle where the counter already holds
    // WAIT_MAX and memory is still not ready; a ready in that same cycle wins.
    assign w_waitState  = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);
    assign w_timeoutHit = (WAIT_MAX > 0) && w_waitState && !mem_ready &&
                          (r_waitCnt == WCNT_W'(WAIT_MAX));

    // State register.
    always_ff @(posedge CLK or posedge FSMRST) begin
        if (FSMRST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode. Every output defaults to 0 so that any
    // state only lists what it asserts; unused encodings fall into the
    // default branch and behave exactly like TRAP.
    always_comb begin
        w_nextState = r_state;
        w_retire    = 1'b0;
        w_rfwe      = 1'b0;
        w_mwe       = 1'b0;
        IRWE        = 1'b0;
        PCE         = 1'b0;
        ALU_sel     = 4'b0000;
        M_to_RF_sel = 1'b0;
        ALU_in_sel1 = 2'b00;
        ALU_in_sel2 = 2'b00;
        RFD_sel     = 1'b0;
        ID_sel      = 1'b0;
        PC_sel      = 2'b00;
        case (r_state)
            S_FETCH: begin
                ALU_in_sel2 = 2'b01;
                ALU_sel     = ALU_ADD;
                IRWE        = mem_ready;
                PCE         = mem_ready;
                if (mem_ready) begin
                    w_nextState = S_DECODE;
                end else if (w_timeoutHit) begin
                    w_nextState = S_TRAP;
                end
            end
            S_DECODE: begin
                ALU_in_sel2 = 2'b10;
                ALU_sel     = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW, OP_ADDI: w_nextState = S_MEM_ADDR;
                    OP_RTYPE: w_nextState = w_functLegal ? S_EXECUTE : S_TRAP;
                    OP_BEQ:   w_nextState = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:   w_nextState = S_BRANCH;
`endif
                    OP_J:     w_nextState = S_JUMP;
                    default:  w_nextState = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                ALU_in_sel1 = 2'b01;
                ALU_in_sel2 = 2'b10;
                ALU_sel     = ALU_ADD;
                case (opcode)
                    OP_LW:   w_nextState = S_MEM_READ;
                    OP_SW:   w_nextState = S_MEM_WRITE;
                    OP_ADDI: w_nextState = S_IMM_WB;
                    default: w_nextState = S_TRAP;
                endcase
            end
            S_MEM_READ: begin
                ID_sel = 1'b1;
                if (mem_ready) begin
                    w_nextState = S_MEM_WB;
                end else if (w_timeoutHit) begin
                    w_nextState = S_TRAP;
                end
            end
            S_MEM_WB: begin
                w_rfwe      = 1'b1;
                M_to_RF_sel = 1'b1;
                w_nextState = S_FETCH;
                w_retire    = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mwe  = 1'b1;
                ID_sel = 1'b1;
                if (mem_ready) begin
                    w_nextState = S_FETCH;
                    w_retire    = 1'b1;
                end else if (w_timeoutHit) begin
                    w_nextState = S_TRAP;
                end
            end
            S_EXECUTE: begin
                ALU_in_sel1 = w_execIn1;
                ALU_in_sel2 = 2'b00;
                ALU_sel     = w_execAluSel;
                w_nextState = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_rfwe      = 1'b1;
                RFD_sel     = 1'b1;
                w_nextState = S_FETCH;
                w_retire    = 1'b1;
            end
            S_IMM_WB: begin
                w_rfwe      = 1'b1;
                w_nextState = S_FETCH;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                ALU_in_sel1 = 2'b01;
                ALU_in_sel2 = 2'b00;
                ALU_sel     = ALU_SUB;
                PC_sel      = 2'b01;
`ifdef MC_CTRL_BNE_EN
                PCE         = r_isBne ? ~zero : zero;
`else
                PCE         = zero;
`endif
                w_nextState = S_FETCH;
                w_retire    = 1'b1;
            end
            S_JUMP: begin
                PCE         = 1'b1;
                PC_sel      = 2'b10;
                w_nextState = S_FETCH;
                w_retire    = 1'b1;
            end
            default: begin
                w_nextState = S_FETCH;
            end
        endcase
    end

    // The write enables are also masked by reset directly so a reset in the
    // middle of a store or writeback kills the write without waiting on the
    // state register to propagate.
    assign RFWE = w_rfwe & ~FSMRST;
    assign MWE  = w_mwe & ~FSMRST;

    // Consecutive memory-stall counter; any completed access, timeout or
    // state change restarts it from zero.
    always_ff @(posedge CLK or posedge FSMRST) begin
        if (FSMRST) begin
            r_waitCnt <= '0;
        end else if (w_waitState && !mem_ready && !w_timeoutHit) begin
            r_waitCnt <= r_waitCnt + WCNT_W'(1);
        end else begin
            r_waitCnt <= '0;
        end
    end

    // Retired-instruction counter and the sticky trap-cause flags.
    always_ff @(posedge CLK or posedge FSMRST) begin
        if (FSMRST) begin
            r_instrCount <= '0;
            r_illegal    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_retire) begin
                r_instrCount <= r_instrCount + CNT_W'(1);
            end
            if ((r_state == S_DECODE) && (w_nextState == S_TRAP)) begin
                r_illegal <= 1'b1;
            end
            if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef MC_CTRL_BNE_EN
    // Remember whether the branch being decoded is BNE so BRANCH stays a
    // function of state and zero only.
    always_ff @(posedge CLK or posedge FSMRST) begin
        if (FSMRST) begin
            r_isBne <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_isBne <= (opcode == OP_BNE);
        end
    end
`endif

    assign illegal_instr = r_illegal;
    assign timeout       = r_timeout;
    assign instr_count   = r_instrCount;
    assign state         = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//
// Directed bench for mc_ctrl_fsm. A table of single-instruction vectors
// (mem_ready held high) checks the state path, write enables on every cycle
// and the datapath selects in one characteristic state per instruction.
// Hand-written sequences cover memory stalls, the wait-timeout boundary,
// the timeout trap and a reset in the middle of a store.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    logic        CLK = 1'b0;
    logic        FSMRST;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        RFWE, MWE, IRWE, PCE;
    logic [3:0]  ALU_sel;
    logic        M_to_RF_sel;
    logic [1:0]  ALU_in_sel1, ALU_in_sel2;
    logic        RFD_sel, ID_sel;
    logic [1:0]  PC_sel;
    logic        illegal_instr, timeout;
    logic [15:0] instr_count;
    logic [3:0]  state;

    int          nChecks = 0;
    int          nFail   = 0;
    int          expCount = 0;
    logic        expIll  = 1'b0;

    mc_ctrl_fsm #(.WAIT_MAX(15), .CNT_W(16)) dut (
        .CLK(CLK), .FSMRST(FSMRST), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .RFWE(RFWE), .MWE(MWE),
        .IRWE(IRWE), .PCE(PCE), .ALU_sel(ALU_sel), .M_to_RF_sel(M_to_RF_sel),
        .ALU_in_sel1(ALU_in_sel1), .ALU_in_sel2(ALU_in_sel2),
        .RFD_sel(RFD_sel), .ID_sel(ID_sel), .PC_sel(PC_sel),
        .illegal_instr(illegal_instr), .timeout(timeout),
        .instr_count(instr_count), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0]      opcode;
        logic [5:0]      funct;
        logic            zero;
        logic [2:0]      nStates;
        logic [5:0][3:0] seq;
        logic [3:0]      chkState;
        logic [3:0]      aluSel;
        logic [1:0]      in1;
        logic [1:0]      in2;
        logic [1:0]      pcSel;
        logic            pce;
        logic            retires;
        logic            illegal;
    } vec_t;

    vec_t vecs[$];

    // Build one table record.
    function automatic vec_t makeVec(logic [5:0] op, logic [5:0] fn, logic z,
                                     int n, logic [3:0] s0, logic [3:0] s1,
                                     logic [3:0] s2, logic [3:0] s3,
                                     logic [3:0] s4, logic [3:0] s5,
                                     logic [3:0] chk, logic [3:0] sel,
                                     logic [1:0] i1, logic [1:0] i2,
                                     logic [1:0] pcs, logic pc,
                                     logic ret, logic ill);
        vec_t v;
        v.opcode = op;   v.funct = fn;   v.zero = z;
        v.nStates = 3'(n);
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
        v.seq[3] = s3; v.seq[4] = s4; v.seq[5] = s5;
        v.chkState = chk; v.aluSel = sel; v.in1 = i1; v.in2 = i2;
        v.pcSel = pcs; v.pce = pc; v.retires = ret; v.illegal = ill;
        return v;
    endfunction

    // Write enables expected for a given state encoding.
    function automatic logic expRfwe(logic [3:0] s);
        return (s == 4'd4) || (s == 4'd7) || (s == 4'd10);
    endfunction

    function automatic logic expMwe(logic [3:0] s);
        return (s == 4'd5);
    endfunction

    // Compare one value and log a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Run one table vector from FETCH back to FETCH with mem_ready=1.
    task automatic applyStimulus(input vec_t v, input int idx);
        opcode    = v.opcode;
        funct     = v.funct;
        zero      = v.zero;
        mem_ready = 1'b1;
        #1;
        for (int k = 0; k < int'(v.nStates); k++) begin
            if (k > 0) step();
            checkOutput($sformatf("v%0d state[%0d]", idx, k), 32'(state), 32'(v.seq[k]));
            checkOutput($sformatf("v%0d RFWE[%0d]", idx, k), 32'(RFWE), 32'(expRfwe(v.seq[k])));
            checkOutput($sformatf("v%0d MWE[%0d]", idx, k), 32'(MWE), 32'(expMwe(v.seq[k])));
            if (v.seq[k] == 4'd0) begin
                checkOutput($sformatf("v%0d IRWE fetch[%0d]", idx, k), 32'(IRWE), 32'd1);
            end
            if (v.seq[k] == v.chkState) begin
                checkOutput($sformatf("v%0d ALU_sel", idx), 32'(ALU_sel), 32'(v.aluSel));
                checkOutput($sformatf("v%0d ALU_in_sel1", idx), 32'(ALU_in_sel1), 32'(v.in1));
                checkOutput($sformatf("v%0d ALU_in_sel2", idx), 32'(ALU_in_sel2), 32'(v.in2));
                checkOutput($sformatf("v%0d PC_sel", idx), 32'(PC_sel), 32'(v.pcSel));
                checkOutput($sformatf("v%0d PCE", idx), 32'(PCE), 32'(v.pce));
            end
        end
        if (v.retires) expCount++;
        if (v.illegal) expIll = 1'b1;
        checkOutput($sformatf("v%0d instr_count", idx), 32'(instr_count), 32'(expCount));
        checkOutput($sformatf("v%0d illegal_instr", idx), 32'(illegal_instr), 32'(expIll));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Table: opcode, funct, zero, n, path, check state, sel, in1, in2, pcsel, pce, retires, illegal
        vecs.push_back(makeVec(6'b100011, 6'b0, 0, 6, 0, 1, 2, 3, 4, 0, 4, 4'b0000, 0, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b101011, 6'b0, 0, 5, 0, 1, 2, 5, 0, 0, 5, 4'b0000, 0, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b001000, 6'b0, 0, 5, 0, 1, 2, 10, 0, 0, 2, 4'b0010, 1, 2, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b000000, 6'b100000, 0, 5, 0, 1, 6, 7, 0, 0, 6, 4'b0010, 1, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b000000, 6'b100010, 0, 5, 0, 1, 6, 7, 0, 0, 6, 4'b0000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b000000, 6'b100100, 0, 5, 0, 1, 6, 7, 0, 0, 6, 4'b1000, 1, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b000000, 6'b100101, 0, 5, 0, 1, 6, 7, 0, 0, 6, 4'b1001, 1, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b000000, 6'b100110, 0, 5, 0, 1, 6, 7, 0, 0, 6, 4'b1010, 1, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b000000, 6'b000100, 0, 5, 0, 1, 6, 7, 0, 0, 6, 4'b0011, 1, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b000000, 6'b000111, 0, 5, 0, 1, 6, 7, 0, 0, 6, 4'b0111, 1, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b000000, 6'b000000, 0, 5, 0, 1, 6, 7, 0, 0, 6, 4'b0011, 2, 0, 0, 0, 1, 0));
        vecs.push_back(makeVec(6'b000100, 6'b0, 1, 4, 0, 1, 8, 0, 0, 0, 8, 4'b0000, 1, 0, 1, 1, 1, 0));
        vecs.push_back(makeVec(6'b000100, 6'b0, 0, 4, 0, 1, 8, 0, 0, 0, 8, 4'b0000, 1, 0, 1, 0, 1, 0));
        vecs.push_back(makeVec(6'b000010, 6'b0, 0, 4, 0, 1, 9, 0, 0, 0, 9, 4'b0000, 0, 0, 2, 1, 1, 0));
`ifdef MC_CTRL_BNE_EN
        vecs.push_back(makeVec(6'b000101, 6'b0, 0, 4, 0, 1, 8, 0, 0, 0, 8, 4'b0000, 1, 0, 1, 1, 1, 0));
        vecs.push_back(makeVec(6'b000101, 6'b0, 1, 4, 0, 1, 8, 0, 0, 0, 8, 4'b0000, 1, 0, 1, 0, 1, 0));
`else
        vecs.push_back(makeVec(6'b000101, 6'b0, 0, 4, 0, 1, 11, 0, 0, 0, 11, 4'b0000, 0, 0, 0, 0, 0, 1));
`endif
        vecs.push_back(makeVec(6'b111111, 6'b0, 0, 4, 0, 1, 11, 0, 0, 0, 11, 4'b0000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(makeVec(6'b000000, 6'b000001, 0, 4, 0, 1, 11, 0, 0, 0, 11, 4'b0000, 0, 0, 0, 0, 0, 1));

        // Reset state.
        FSMRST = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset instr_count", 32'(instr_count), 32'd0);
        checkOutput("reset illegal_instr", 32'(illegal_instr), 32'd0);
        checkOutput("reset timeout", 32'(timeout), 32'd0);
        FSMRST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // LW with 15 stall cycles in MEM_READ, ready on the 16th: no trap.
        $display("[TB] MEM_READ stall at the timeout boundary");
        opcode = 6'b100011; mem_ready = 1'b1;
        step(); step();
        checkOutput("bnd MEM_ADDR", 32'(state), 32'd2);
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("bnd MEM_READ[%0d]", i), 32'(state), 32'd3);
            checkOutput($sformatf("bnd ID_sel[%0d]", i), 32'(ID_sel), 32'd1);
            if (i == 15) mem_ready = 1'b1;
            step();
        end
        checkOutput("bnd MEM_WB", 32'(state), 32'd4);
        checkOutput("bnd timeout", 32'(timeout), 32'd0);
        step();
        expCount++;
        checkOutput("bnd FETCH", 32'(state), 32'd0);
        checkOutput("bnd instr_count", 32'(instr_count), 32'(expCount));

        // SW with three stall cycles in MEM_WRITE.
        $display("[TB] SW stall");
        opcode = 6'b101011; mem_ready = 1'b1;
        step(); step();
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("sw state[%0d]", i), 32'(state), 32'd5);
            checkOutput($sformatf("sw MWE[%0d]", i), 32'(MWE), 32'd1);
            if (i == 3) mem_ready = 1'b1;
            step();
        end
        expCount++;
        checkOutput("sw FETCH", 32'(state), 32'd0);
        checkOutput("sw instr_count", 32'(instr_count), 32'(expCount));

        // FETCH timeout after 16 stall cycles.
        $display("[TB] FETCH timeout");
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("to state[%0d]", i), 32'(state), 32'd0);
            checkOutput($sformatf("to IRWE[%0d]", i), 32'(IRWE), 32'd0);
            checkOutput($sformatf("to PCE[%0d]", i), 32'(PCE), 32'd0);
            checkOutput($sformatf("to ALU_sel[%0d]", i), 32'(ALU_sel), 32'd2);
            checkOutput($sformatf("to ALU_in_sel2[%0d]", i), 32'(ALU_in_sel2), 32'd1);
            step();
        end
        checkOutput("to TRAP", 32'(state), 32'd11);
        checkOutput("to timeout", 32'(timeout), 32'd1);
        checkOutput("to instr_count", 32'(instr_count), 32'(expCount));
        checkOutput("to TRAP enables", 32'({RFWE, MWE, IRWE, PCE}), 32'd0);
        mem_ready = 1'b1;
        step();
        checkOutput("to back FETCH", 32'(state), 32'd0);
        checkOutput("to instr_count after", 32'(instr_count), 32'(expCount));
        checkOutput("to timeout sticky", 32'(timeout), 32'd1);

        // Reset in the middle of a store.
        $display("[TB] reset during MEM_WRITE");
        opcode = 6'b101011; mem_ready = 1'b1;
        step(); step();
        mem_ready = 1'b0;
        step();
        checkOutput("rst pre state", 32'(state), 32'd5);
        checkOutput("rst pre MWE", 32'(MWE), 32'd1);
        #2 FSMRST = 1'b1;
        #1;
        checkOutput("rst MWE", 32'(MWE), 32'd0);
        checkOutput("rst RFWE", 32'(RFWE), 32'd0);
        checkOutput("rst state", 32'(state), 32'd0);
        checkOutput("rst instr_count", 32'(instr_count), 32'd0);
        checkOutput("rst illegal_instr", 32'(illegal_instr), 32'd0);
        checkOutput("rst timeout", 32'(timeout), 32'd0);
        expCount = 0;
        expIll   = 1'b0;
        @(negedge CLK);
        FSMRST = 1'b0;
        applyStimulus(vecs[0], 99);
        checkOutput("post-reset timeout", 32'(timeout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum number of consecutive mem_ready=0 cycles tolerated in a memory state; 0 disables the timeout.
REQ-002 SHALL have parameter CNT_W, default 16: width of instr_count.
REQ-003 SHALL have port CLK, input, 1: clock; all state updates occur on its rising edge.
REQ-004 SHALL have port FSMRST, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have inputs opcode (6), funct (6), zero (1, ALU result equals zero) and mem_ready (1, memory access completes this cycle).
REQ-006 SHALL have 1-bit enable outputs RFWE, MWE, IRWE and PCE.
REQ-007 SHALL have select outputs ALU_sel (4), M_to_RF_sel (1), ALU_in_sel1 (2), ALU_in_sel2 (2), RFD_sel (1), ID_sel (1) and PC_sel (2).
REQ-008 SHALL have outputs illegal_instr (1, sticky), timeout (1, sticky), instr_count (CNT_W, retired instructions) and state (4, debug).

Function
REQ-009 SHALL implement a Moore FSM with encodings FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, IMM_WB=10 and TRAP=11; the only Mealy terms are the mem_ready and zero qualifications in REQ-012 and REQ-019.
REQ-010 SHALL drive every output not listed for the current state to 0; no X values are permitted; unused encodings SHALL behave as TRAP.
REQ-011 SHALL decode DECODE by opcode: LW 100011 and SW 101011 go to MEM_ADDR; ADDI 001000 goes to MEM_ADDR; R-type 000000 with a legal funct goes to EXECUTE; BEQ 000100 goes to BRANCH; J 000010 goes to JUMP; all other cases go to TRAP.
REQ-012 FETCH SHALL drive ALU_in_sel2=01 and ALU_sel=ADD (0010); IRWE and PCE SHALL each equal mem_ready; the FSM SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-013 DECODE SHALL drive ALU_in_sel2=10 and ALU_sel=ADD.
REQ-014 MEM_ADDR SHALL drive ALU_in_sel1=01, ALU_in_sel2=10 and ALU_sel=ADD, then go to MEM_READ for LW, MEM_WRITE for SW or IMM_WB for ADDI.
REQ-015 MEM_READ SHALL drive ID_sel=1 and wait for mem_ready=1, then go to MEM_WB; MEM_WB SHALL drive RFWE=1 and M_to_RF_sel=1, then go to FETCH.
REQ-016 MEM_WRITE SHALL drive MWE=1 and ID_sel=1 for the whole state and wait for mem_ready=1, then go to FETCH.
REQ-017 EXECUTE SHALL drive ALU_in_sel1=01 and ALU_in_sel2=00, with ALU_sel set from funct: 100000 gives ADD 0010, 100010 gives SUB 0000, 100100 gives AND 1000, 100101 gives OR 1001, 100110 gives XOR 1010, 000100 gives SLL 0011, 000111 gives SRA 0111, and 000000 gives SLL 0011 with ALU_in_sel1 overridden to 10.
REQ-018 ALU_WB SHALL drive RFWE=1 and RFD_sel=1; IMM_WB SHALL drive RFWE=1 and RFD_sel=0; both SHALL then go to FETCH.
REQ-019 BRANCH SHALL drive ALU_in_sel1=01, ALU_in_sel2=00, ALU_sel=SUB, PC_sel=01 and PCE=zero, then go to FETCH.
REQ-020 JUMP SHALL drive PCE=1 and PC_sel=10, then go to FETCH.
REQ-021 A wait counter SHALL count consecutive mem_ready=0 cycles in FETCH, MEM_READ and MEM_WRITE, and SHALL clear on leaving any of those states.
REQ-022 When WAIT_MAX>0 and the wait counter equals WAIT_MAX with mem_ready=0, the FSM SHALL go to TRAP and set timeout; if mem_ready=1 in that same cycle, the access completes normally with no trap.
REQ-023 Entry to TRAP from DECODE SHALL set illegal_instr.
REQ-024 TRAP SHALL drive all enables to 0 for exactly 1 cycle, then go to FETCH.
REQ-025 instr_count SHALL increment by 1 on each transition into FETCH from any state other than TRAP, and SHALL wrap modulo 2^CNT_W.
REQ-026 The state output SHALL equal the current state encoding.

Reset
REQ-027 While FSMRST=1, the FSM SHALL hold state FETCH, with the wait counter, instr_count, illegal_instr and timeout all held at 0.
REQ-028 Assertion of FSMRST mid-operation SHALL deassert MWE and RFWE within the same cycle, with no clock edge required.
REQ-029 After FSMRST deasserts, the first rising CLK edge SHALL evaluate FETCH normally.

Configuration
REQ-030 When macro MC_CTRL_BNE_EN is defined, opcode 000101 (BNE) SHALL go from DECODE to BRANCH with PCE=!zero and all other BRANCH outputs per REQ-019.
REQ-031 When MC_CTRL_BNE_EN is undefined, opcode 000101 SHALL be treated as illegal per REQ-011 and REQ-023.

Verification
REQ-032 Bench SHALL apply reset, then LW with mem_ready=1 always, and check the state sequence 0,1,2,3,4,0, RFWE=1 only in state 4, and instr_count=1.
REQ-033 Bench SHALL apply SW with mem_ready held 0 for 3 cycles in MEM_WRITE, and check that MWE=1 for 4 cycles, the FSM stays in state 5, and then returns to FETCH.
REQ-034 Bench SHALL set WAIT_MAX=15 and hold mem_ready=0 in FETCH, and check TRAP entry after 16 wait cycles, timeout=1, and instr_count unchanged.
REQ-035 Bench SHALL apply opcode 111111, and check DECODE, then TRAP, then FETCH, with illegal_instr=1; a second test SHALL apply R-type with funct 000000 and check ALU_in_sel1=10 and ALU_sel=0011 in EXECUTE.
REQ-036 Bench SHALL apply BNE with zero=0 in both builds, and check PCE=1 in BRANCH with MC_CTRL_BNE_EN defined, and TRAP with illegal_instr=1 without it.
REQ-037 Bench SHALL assert FSMRST while in MEM_WRITE, and check that MWE falls immediately, state=0, and all counters and flags are 0.
